// File: rtl/region_attr_table.sv
// Programmable region attribute table: NrRules {base,length,attr} entries, resolved by a
// multi-cycle priority scan. Optional per-entry write lock is enabled by REGION_ATTR_LOCK_EN.
module region_attr_table #(
  parameter int unsigned                    NrRules       = 8,
  parameter int unsigned                    RulesPerCycle = 2,
  parameter int unsigned                    AddrWidth     = 64,
  parameter logic [NrRules*AddrWidth-1:0]   RstBase       = '0,
  parameter logic [NrRules*AddrWidth-1:0]   RstLength     = '0,
  parameter logic [NrRules*3-1:0]           RstAttr       = '0,
  parameter logic [2:0]                     DefaultAttr   = 3'b000,
  localparam int unsigned                   IdxW          = (NrRules > 1) ? $clog2(NrRules) : 1
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 cfg_req_i,
  input  logic                 cfg_we_i,
  input  logic [IdxW-1:0]      cfg_idx_i,
  input  logic [1:0]           cfg_sel_i,
  input  logic [AddrWidth-1:0] cfg_wdata_i,
  output logic                 cfg_gnt_o,
  output logic                 cfg_rvalid_o,
  output logic [AddrWidth-1:0] cfg_rdata_o,
  output logic                 cfg_err_o,
  input  logic                 lk_valid_i,
  input  logic [AddrWidth-1:0] lk_addr_i,
  output logic                 lk_ready_o,
  output logic                 lk_valid_o,
  output logic                 lk_hit_o,
  output logic [IdxW-1:0]      lk_idx_o,
  output logic [2:0]           lk_attr_o
);

  localparam int unsigned Steps = (NrRules + RulesPerCycle - 1) / RulesPerCycle;
  localparam int unsigned StepW = (Steps > 1) ? $clog2(Steps) : 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // The end of the region is formed one bit wider so a region touching the top never wraps.
  function automatic logic in_region(input logic [AddrWidth-1:0] addr,
                                     input logic [AddrWidth-1:0] base,
                                     input logic [AddrWidth-1:0] len);
    logic [AddrWidth:0] end_w;
    end_w = {1'b0, base} + {1'b0, len};
    return (len != {AddrWidth{1'b0}}) && (addr >= base) && ({1'b0, addr} < end_w);
  endfunction

  logic [AddrWidth-1:0] base_q [NrRules];
  logic [AddrWidth-1:0] len_q  [NrRules];
  logic [2:0]           attr_q [NrRules];
`ifdef REGION_ATTR_LOCK_EN
  logic [NrRules-1:0]   lock_q;
`endif

  state_e               state_q, state_d;
  logic [StepW-1:0]     step_q;
  logic [AddrWidth-1:0] addr_q;
  logic                 found_q, found_d;
  logic [IdxW-1:0]      fidx_q, fidx_d;
  logic [2:0]           fattr_q, fattr_d;

  logic                 cfg_gnt, lk_ready, lk_accept, last_step;
  logic                 idx_ok, sel_ok, entry_locked, cfg_fault, cfg_wr_en;
  logic                 cfg_rvalid_q, cfg_err_q;
  logic [AddrWidth-1:0] cfg_rdata_q, cfg_rdata_d;
  logic                 lk_valid_q, lk_valid_d, lk_hit_q, lk_hit_d;
  logic [IdxW-1:0]      lk_idx_q, lk_idx_d;
  logic [2:0]           lk_attr_q, lk_attr_d;

  // The table only changes while idle, so a scan always sees a stable snapshot.
  assign cfg_gnt   = cfg_req_i && (state_q == ST_IDLE);
  assign lk_ready  = (state_q == ST_IDLE) && !cfg_req_i;
  assign lk_accept = lk_valid_i && lk_ready;
  assign last_step = (step_q == StepW'(Steps - 1));

  always_comb begin
    idx_ok       = ({{(32-IdxW){1'b0}}, cfg_idx_i} < NrRules);
    sel_ok       = (cfg_sel_i != 2'd3);
    entry_locked = 1'b0;
`ifdef REGION_ATTR_LOCK_EN
    if (idx_ok) begin
      entry_locked = lock_q[cfg_idx_i];
    end else begin
      entry_locked = 1'b0;
    end
`endif
    cfg_fault = !idx_ok || !sel_ok || (cfg_we_i && entry_locked);
    cfg_wr_en = cfg_gnt && cfg_we_i && !cfg_fault;
  end

  always_comb begin
    cfg_rdata_d = {AddrWidth{1'b0}};
    if (cfg_gnt && !cfg_we_i && idx_ok && sel_ok) begin
      case (cfg_sel_i)
        2'd0:    cfg_rdata_d = base_q[cfg_idx_i];
        2'd1:    cfg_rdata_d = len_q[cfg_idx_i];
        2'd2:    cfg_rdata_d = {{(AddrWidth-4){1'b0}}, entry_locked, attr_q[cfg_idx_i]};
        default: cfg_rdata_d = {AddrWidth{1'b0}};
      endcase
    end else begin
      cfg_rdata_d = {AddrWidth{1'b0}};
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < NrRules; i++) begin
        base_q[i] <= RstBase[i*AddrWidth +: AddrWidth];
        len_q[i]  <= RstLength[i*AddrWidth +: AddrWidth];
        attr_q[i] <= RstAttr[i*3 +: 3];
      end
`ifdef REGION_ATTR_LOCK_EN
      lock_q <= {NrRules{1'b0}};
`endif
    end else if (cfg_wr_en) begin
      case (cfg_sel_i)
        2'd0: base_q[cfg_idx_i] <= cfg_wdata_i;
        2'd1: len_q[cfg_idx_i]  <= cfg_wdata_i;
        2'd2: begin
          attr_q[cfg_idx_i] <= cfg_wdata_i[2:0];
`ifdef REGION_ATTR_LOCK_EN
          lock_q[cfg_idx_i] <= cfg_wdata_i[3];
`endif
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cfg_rvalid_q <= 1'b0;
      cfg_rdata_q  <= {AddrWidth{1'b0}};
      cfg_err_q    <= 1'b0;
    end else begin
      cfg_rvalid_q <= cfg_gnt;
      cfg_rdata_q  <= cfg_rdata_d;
      cfg_err_q    <= cfg_gnt && cfg_fault;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: state_d = lk_accept ? ST_SCAN : ST_IDLE;
      ST_SCAN: state_d = last_step ? ST_DONE : ST_SCAN;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    lk_valid_d = 1'b0;
    lk_hit_d   = 1'b0;
    lk_idx_d   = {IdxW{1'b0}};
    lk_attr_d  = 3'b000;
    case (state_q)
      ST_DONE: begin
        lk_valid_d = 1'b1;
        lk_hit_d   = found_q;
        lk_idx_d   = found_q ? fidx_q : {IdxW{1'b0}};
        lk_attr_d  = found_q ? fattr_q : DefaultAttr;
      end
      default: begin
        lk_valid_d = 1'b0;
      end
    endcase
  end

  // Lanes are visited in ascending index and earlier steps cover lower indices,
  // so the first match recorded is the lowest-index one.
  always_comb begin
    logic [31:0] lane;
    logic        hit_lane;
    lane     = 32'd0;
    hit_lane = 1'b0;
    found_d  = found_q;
    fidx_d   = fidx_q;
    fattr_d  = fattr_q;
    for (int j = 0; j < RulesPerCycle; j++) begin
      lane     = {{(32-StepW){1'b0}}, step_q} * RulesPerCycle + 32'(j);
      hit_lane = (lane < NrRules) && !found_d &&
                 in_region(addr_q, base_q[lane[IdxW-1:0]], len_q[lane[IdxW-1:0]]);
      fidx_d   = hit_lane ? lane[IdxW-1:0] : fidx_d;
      fattr_d  = hit_lane ? attr_q[lane[IdxW-1:0]] : fattr_d;
      found_d  = found_d | hit_lane;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      step_q  <= {StepW{1'b0}};
      addr_q  <= {AddrWidth{1'b0}};
      found_q <= 1'b0;
      fidx_q  <= {IdxW{1'b0}};
      fattr_q <= 3'b000;
    end else if (lk_accept) begin
      step_q  <= {StepW{1'b0}};
      addr_q  <= lk_addr_i;
      found_q <= 1'b0;
      fidx_q  <= {IdxW{1'b0}};
      fattr_q <= DefaultAttr;
    end else if (state_q == ST_SCAN) begin
      step_q  <= step_q + StepW'(1);
      found_q <= found_d;
      fidx_q  <= fidx_d;
      fattr_q <= fattr_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      lk_valid_q <= 1'b0;
      lk_hit_q   <= 1'b0;
      lk_idx_q   <= {IdxW{1'b0}};
      lk_attr_q  <= 3'b000;
    end else begin
      lk_valid_q <= lk_valid_d;
      lk_hit_q   <= lk_hit_d;
      lk_idx_q   <= lk_idx_d;
      lk_attr_q  <= lk_attr_d;
    end
  end

  assign cfg_gnt_o    = cfg_gnt;
  assign cfg_rvalid_o = cfg_rvalid_q;
  assign cfg_rdata_o  = cfg_rdata_q;
  assign cfg_err_o    = cfg_err_q;
  assign lk_ready_o   = lk_ready;
  assign lk_valid_o   = lk_valid_q;
  assign lk_hit_o     = lk_hit_q;
  assign lk_idx_o     = lk_idx_q;
  assign lk_attr_o    = lk_attr_q;

endmodule

// File: tb/tb_region_attr_table.sv
// Directed bench for region_attr_table: vector table for config/lookup plus hand-written
// sequences for arbitration, back-to-back access, mid-scan reset and a small second instance.
module tb_region_attr_table;

  localparam int NR = 8;
  localparam int AW = 64;
  localparam logic [NR*AW-1:0] RST_BASE = {64'h5000, 448'h0};
  localparam logic [NR*AW-1:0] RST_LEN  = {64'h100, 448'h0};
  localparam logic [NR*3-1:0]  RST_ATTR = {3'b011, 21'h0};
  localparam logic [2:0]       DEF_ATTR = 3'b010;
`ifdef REGION_ATTR_LOCK_EN
  localparam logic LOCK = 1'b1;
`else
  localparam logic LOCK = 1'b0;
`endif

  logic          clk, rst;
  logic          cfg_req, cfg_we, cfg_gnt, cfg_rvalid, cfg_err;
  logic [2:0]    cfg_idx;
  logic [1:0]    cfg_sel;
  logic [AW-1:0] cfg_wdata, cfg_rdata;
  logic          lk_vi, lk_ready, lk_vo, lk_hit;
  logic [AW-1:0] lk_addr;
  logic [2:0]    lk_idx, lk_attr;

  logic          b_req, b_we, b_gnt, b_rvalid, b_err;
  logic [2:0]    b_idx;
  logic [1:0]    b_sel;
  logic [AW-1:0] b_wdata, b_rdata;
  logic          b_vi, b_ready, b_vo, b_hit;
  logic [AW-1:0] b_addr;
  logic [2:0]    b_lidx, b_attr;

  int errors = 0;
  int checks = 0;

  region_attr_table #(
    .NrRules(NR), .RulesPerCycle(2), .AddrWidth(AW), .RstBase(RST_BASE),
    .RstLength(RST_LEN), .RstAttr(RST_ATTR), .DefaultAttr(DEF_ATTR)
  ) dut (
    .clk_i(clk), .rst_i(rst), .cfg_req_i(cfg_req), .cfg_we_i(cfg_we), .cfg_idx_i(cfg_idx),
    .cfg_sel_i(cfg_sel), .cfg_wdata_i(cfg_wdata), .cfg_gnt_o(cfg_gnt), .cfg_rvalid_o(cfg_rvalid),
    .cfg_rdata_o(cfg_rdata), .cfg_err_o(cfg_err), .lk_valid_i(lk_vi), .lk_addr_i(lk_addr),
    .lk_ready_o(lk_ready), .lk_valid_o(lk_vo), .lk_hit_o(lk_hit), .lk_idx_o(lk_idx), .lk_attr_o(lk_attr)
  );

  region_attr_table #(
    .NrRules(5), .RulesPerCycle(5), .AddrWidth(AW), .DefaultAttr(3'b001)
  ) dut_b (
    .clk_i(clk), .rst_i(rst), .cfg_req_i(b_req), .cfg_we_i(b_we), .cfg_idx_i(b_idx),
    .cfg_sel_i(b_sel), .cfg_wdata_i(b_wdata), .cfg_gnt_o(b_gnt), .cfg_rvalid_o(b_rvalid),
    .cfg_rdata_o(b_rdata), .cfg_err_o(b_err), .lk_valid_i(b_vi), .lk_addr_i(b_addr),
    .lk_ready_o(b_ready), .lk_valid_o(b_vo), .lk_hit_o(b_hit), .lk_idx_o(b_lidx), .lk_attr_o(b_attr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cfg_access(input logic we, input logic [2:0] idx, input logic [1:0] sel,
                            input logic [63:0] wd, output logic [63:0] rd, output logic er);
    cfg_req = 1'b1; cfg_we = we; cfg_idx = idx; cfg_sel = sel; cfg_wdata = wd;
    #1;
    chk("cfg_gnt", {63'd0, cfg_gnt}, 64'd1);
    @(posedge clk); #1;
    cfg_req = 1'b0; cfg_we = 1'b0;
    chk("cfg_rvalid", {63'd0, cfg_rvalid}, 64'd1);
    rd = cfg_rdata;
    er = cfg_err;
  endtask

  task automatic do_lookup(input logic [63:0] a, output logic hit, output logic [2:0] idx,
                           output logic [2:0] attr, output int lat);
    lk_addr = a; lk_vi = 1'b1;
    #1;
    chk("lk_ready", {63'd0, lk_ready}, 64'd1);
    @(posedge clk); #1;
    lk_vi = 1'b0;
    lat = -1; hit = 1'b0; idx = 3'd0; attr = 3'd0;
    for (int n = 1; n <= 20; n++) begin
      @(posedge clk); #1;
      if (lk_vo) begin
        lat = n; hit = lk_hit; idx = lk_idx; attr = lk_attr;
        break;
      end
    end
  endtask

  typedef enum logic [1:0] {OP_WR, OP_RD, OP_LK} op_e;
  typedef struct {
    op_e         op;
    logic [2:0]  idx;
    logic [1:0]  sel;
    logic [63:0] data;
    logic [63:0] exp_data;
    logic        exp_err;
    logic        exp_hit;
    logic [2:0]  exp_idx;
    logic [2:0]  exp_attr;
  } vec_t;

  function automatic vec_t wr(input logic [2:0] i, input logic [1:0] s, input logic [63:0] d, input logic e);
    return '{OP_WR, i, s, d, 64'd0, e, 1'b0, 3'd0, 3'd0};
  endfunction
  function automatic vec_t rd(input logic [2:0] i, input logic [1:0] s, input logic [63:0] x, input logic e);
    return '{OP_RD, i, s, 64'd0, x, e, 1'b0, 3'd0, 3'd0};
  endfunction
  function automatic vec_t lk(input logic [63:0] a, input logic h, input logic [2:0] i, input logic [2:0] at);
    return '{OP_LK, 3'd0, 2'd0, a, 64'd0, 1'b0, h, i, at};
  endfunction

  vec_t        vecs[$];
  logic [63:0] r;
  logic        e, h;
  logic [2:0]  ix, at;
  int          lat, seen;

  initial begin
    rst = 1'b1; cfg_req = 1'b1; cfg_we = 1'b0; cfg_idx = 3'd0; cfg_sel = 2'd0; cfg_wdata = 64'd0;
    lk_vi = 1'b0; lk_addr = 64'd0;
    b_req = 1'b0; b_we = 1'b0; b_idx = 3'd0; b_sel = 2'd0; b_wdata = 64'd0; b_vi = 1'b0; b_addr = 64'd0;
    @(posedge clk); @(posedge clk); #1;
    chk("rst_gnt_follows_req", {63'd0, cfg_gnt}, 64'd1);
    cfg_req = 1'b0;
    #1;
    chk("rst_lk_ready", {63'd0, lk_ready}, 64'd1);
    chk("rst_lk_valid", {63'd0, lk_vo}, 64'd0);
    chk("rst_cfg_rvalid", {63'd0, cfg_rvalid}, 64'd0);
    chk("rst_lk_attr", {61'd0, lk_attr}, 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    vecs.push_back(rd(3'd7, 2'd0, 64'h5000, 1'b0));
    vecs.push_back(rd(3'd7, 2'd1, 64'h100, 1'b0));
    vecs.push_back(rd(3'd7, 2'd2, 64'h3, 1'b0));
    vecs.push_back(lk(64'h8000_1000, 1'b0, 3'd0, DEF_ATTR));
    vecs.push_back(wr(3'd0, 2'd0, 64'h8000_0000, 1'b0));
    vecs.push_back(wr(3'd0, 2'd1, 64'h4000_0000, 1'b0));
    vecs.push_back(wr(3'd0, 2'd2, 64'h5, 1'b0));
    vecs.push_back(lk(64'h8000_1000, 1'b1, 3'd0, 3'b101));
    vecs.push_back(lk(64'hC000_0000, 1'b0, 3'd0, DEF_ATTR));
    vecs.push_back(lk(64'hBFFF_FFFF, 1'b1, 3'd0, 3'b101));
    vecs.push_back(rd(3'd0, 2'd2, 64'h5, 1'b0));
    vecs.push_back(wr(3'd2, 2'd0, 64'h1_0000, 1'b0));
    vecs.push_back(wr(3'd2, 2'd1, 64'h1_0000, 1'b0));
    vecs.push_back(wr(3'd2, 2'd2, 64'h1, 1'b0));
    vecs.push_back(wr(3'd5, 2'd0, 64'h1_8000, 1'b0));
    vecs.push_back(wr(3'd5, 2'd1, 64'h100, 1'b0));
    vecs.push_back(wr(3'd5, 2'd2, 64'h6, 1'b0));
    vecs.push_back(lk(64'h1_8010, 1'b1, 3'd2, 3'b001));
    vecs.push_back(lk(64'h1_0000_0000, 1'b0, 3'd0, DEF_ATTR));
    vecs.push_back(lk(64'h5080, 1'b1, 3'd7, 3'b011));
    vecs.push_back(wr(3'd3, 2'd0, 64'hFFFF_FFFF_FFFF_FF00, 1'b0));
    vecs.push_back(wr(3'd3, 2'd1, 64'h200, 1'b0));
    vecs.push_back(wr(3'd3, 2'd2, 64'h4, 1'b0));
    vecs.push_back(lk(64'h10, 1'b0, 3'd0, DEF_ATTR));
    vecs.push_back(lk(64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 3'd3, 3'b100));
    vecs.push_back(wr(3'd4, 2'd3, 64'h123, 1'b1));
    vecs.push_back(rd(3'd4, 2'd3, 64'h0, 1'b1));
    vecs.push_back(rd(3'd4, 2'd0, 64'h0, 1'b0));
    vecs.push_back(lk(64'h1_0000, 1'b1, 3'd2, 3'b001));
    vecs.push_back(wr(3'd2, 2'd1, 64'h0, 1'b0));
    vecs.push_back(lk(64'h1_8010, 1'b1, 3'd5, 3'b110));
    vecs.push_back(wr(3'd1, 2'd2, 64'h9, 1'b0));
    vecs.push_back(rd(3'd1, 2'd2, LOCK ? 64'h9 : 64'h1, 1'b0));
    vecs.push_back(wr(3'd1, 2'd0, 64'h777, LOCK));
    vecs.push_back(rd(3'd1, 2'd0, LOCK ? 64'h0 : 64'h777, 1'b0));

    foreach (vecs[i]) begin
      case (vecs[i].op)
        OP_WR: begin
          cfg_access(1'b1, vecs[i].idx, vecs[i].sel, vecs[i].data, r, e);
          chk($sformatf("v%0d_wr_err", i), {63'd0, e}, {63'd0, vecs[i].exp_err});
        end
        OP_RD: begin
          cfg_access(1'b0, vecs[i].idx, vecs[i].sel, 64'd0, r, e);
          chk($sformatf("v%0d_rd_data", i), r, vecs[i].exp_data);
          chk($sformatf("v%0d_rd_err", i), {63'd0, e}, {63'd0, vecs[i].exp_err});
        end
        default: begin
          do_lookup(vecs[i].data, h, ix, at, lat);
          chk($sformatf("v%0d_lk_latency", i), 64'(lat), 64'd5);
          chk($sformatf("v%0d_lk_hit", i), {63'd0, h}, {63'd0, vecs[i].exp_hit});
          chk($sformatf("v%0d_lk_idx", i), {61'd0, ix}, {61'd0, vecs[i].exp_idx});
          chk($sformatf("v%0d_lk_attr", i), {61'd0, at}, {61'd0, vecs[i].exp_attr});
        end
      endcase
    end

    // Same-cycle cfg and lookup: cfg wins, lookup is not taken.
    cfg_req = 1'b1; cfg_we = 1'b0; cfg_idx = 3'd0; cfg_sel = 2'd0;
    lk_vi = 1'b1; lk_addr = 64'h8000_1000;
    #1;
    chk("conflict_gnt", {63'd0, cfg_gnt}, 64'd1);
    chk("conflict_ready", {63'd0, lk_ready}, 64'd0);
    @(posedge clk); #1;
    cfg_req = 1'b0; lk_vi = 1'b0;
    chk("conflict_rdata", cfg_rdata, 64'h8000_0000);
    seen = 0;
    for (int n = 0; n < 8; n++) begin
      @(posedge clk); #1;
      if (lk_vo) seen = 1;
    end
    chk("conflict_no_lookup", 64'(seen), 64'd0);

    // cfg request raised during a scan is held off until the FSM is idle again.
    lk_addr = 64'h1_8010; lk_vi = 1'b1;
    @(posedge clk); #1;
    lk_vi = 1'b0;
    cfg_req = 1'b1; cfg_we = 1'b0; cfg_idx = 3'd5; cfg_sel = 2'd2;
    lat = -1;
    for (int n = 0; n <= 20; n++) begin
      if (cfg_gnt) begin
        lat = n;
        break;
      end
      @(posedge clk); #1;
    end
    chk("scan_gnt_delay", 64'(lat), 64'd5);
    chk("scan_result_valid", {63'd0, lk_vo}, 64'd1);
    chk("scan_result_idx", {61'd0, lk_idx}, 64'd5);
    chk("scan_result_attr", {61'd0, lk_attr}, 64'h6);
    @(posedge clk); #1;
    cfg_req = 1'b0;
    chk("scan_cfg_rdata", cfg_rdata, 64'h6);
    chk("lk_valid_one_cycle", {63'd0, lk_vo}, 64'd0);

    // Back-to-back accesses, responses in order; a write is visible to the very next read.
    cfg_req = 1'b1; cfg_we = 1'b0; cfg_idx = 3'd0; cfg_sel = 2'd0;
    @(posedge clk); #1;
    chk("b2b_rd0", cfg_rdata, 64'h8000_0000);
    cfg_idx = 3'd7; cfg_sel = 2'd1;
    @(posedge clk); #1;
    chk("b2b_rd1", cfg_rdata, 64'h100);
    cfg_idx = 3'd3; cfg_sel = 2'd0;
    @(posedge clk); #1;
    chk("b2b_rd2", cfg_rdata, 64'hFFFF_FFFF_FFFF_FF00);
    cfg_we = 1'b1; cfg_idx = 3'd6; cfg_sel = 2'd0; cfg_wdata = 64'hABC;
    @(posedge clk); #1;
    chk("b2b_wr_rvalid", {63'd0, cfg_rvalid}, 64'd1);
    cfg_we = 1'b0;
    @(posedge clk); #1;
    cfg_req = 1'b0;
    chk("b2b_rd_after_wr", cfg_rdata, 64'hABC);

    // Reset in the middle of a scan: no result, table back to reset contents.
    lk_addr = 64'h8000_1000; lk_vi = 1'b1;
    @(posedge clk); #1;
    lk_vi = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("midrst_ready", {63'd0, lk_ready}, 64'd1);
    seen = 0;
    for (int n = 0; n < 8; n++) begin
      if (lk_vo) seen = 1;
      @(posedge clk); #1;
    end
    chk("midrst_no_result", 64'(seen), 64'd0);
    cfg_access(1'b0, 3'd0, 2'd0, 64'd0, r, e);
    chk("midrst_base0", r, 64'h0);
    cfg_access(1'b0, 3'd7, 2'd0, 64'd0, r, e);
    chk("midrst_base7", r, 64'h5000);
    cfg_access(1'b0, 3'd6, 2'd0, 64'd0, r, e);
    chk("midrst_base6", r, 64'h0);
    cfg_access(1'b1, 3'd1, 2'd0, 64'h1, r, e);
    chk("midrst_unlocked_wr_err", {63'd0, e}, 64'd0);
    do_lookup(64'h8000_1000, h, ix, at, lat);
    chk("midrst_lk_hit", {63'd0, h}, 64'd0);
    chk("midrst_lk_attr", {61'd0, at}, {61'd0, DEF_ATTR});

    // Five-entry instance, all lanes in one step: out-of-range index and single-step latency.
    b_req = 1'b1; b_we = 1'b1; b_idx = 3'd6; b_sel = 2'd0; b_wdata = 64'h1;
    @(posedge clk); #1;
    chk("b_bad_idx_wr_err", {63'd0, b_err}, 64'd1);
    b_we = 1'b0; b_idx = 3'd5;
    @(posedge clk); #1;
    chk("b_bad_idx_rd_err", {63'd0, b_err}, 64'd1);
    chk("b_bad_idx_rd_data", b_rdata, 64'd0);
    b_we = 1'b1; b_idx = 3'd4; b_sel = 2'd0; b_wdata = 64'h100;
    @(posedge clk); #1;
    chk("b_good_wr_err", {63'd0, b_err}, 64'd0);
    b_sel = 2'd1; b_wdata = 64'h10;
    @(posedge clk); #1;
    b_sel = 2'd2; b_wdata = 64'h7;
    @(posedge clk); #1;
    b_req = 1'b0; b_we = 1'b0;
    b_addr = 64'h10F; b_vi = 1'b1;
    @(posedge clk); #1;
    b_vi = 1'b0;
    lat = -1;
    for (int n = 1; n <= 20; n++) begin
      @(posedge clk); #1;
      if (b_vo) begin
        lat = n;
        break;
      end
    end
    chk("b_lk_latency", 64'(lat), 64'd2);
    chk("b_lk_hit", {63'd0, b_hit}, 64'd1);
    chk("b_lk_idx", {61'd0, b_lidx}, 64'd4);
    chk("b_lk_attr", {61'd0, b_attr}, 64'h7);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
